// File: rtl/line_loader.sv
// -----------------------------------------------------------------------------
// line_loader
//
// L1 refill / write-through engine sitting between the L1 cache controller and
// the shared memory bus.
//
//   * Read request  : fetches a whole line of LINE_WORDS words as back-to-back
//                     single-word bus reads, streams every word into the cache
//                     data RAM (fill_we/fill_idx/fill_data) and returns the
//                     requested ("critical") word on rdata.
//   * Write request : one single-word bus write (write-through).
//
// Every bus transaction uses the request / accept / busy handshake:
//   request held until bus_acc, address/data presented on the accept edge,
//   read data captured once bus_busy is low; a write completes once bus_acc
//   has dropped again.
//
// Optional feature macro:
//   LINE_LOADER_CRITICAL_WORD_FIRST_EN
//     defined   : the fill starts at the critical word and wraps around.
//     undefined : the fill always runs 0 .. LINE_WORDS-1.
//   Latency and rdata content are identical in both builds.
//
// Parameters:
//   ADDR_W      byte address width
//   DATA_W      word width (power of two, >= 8)
//   LINE_WORDS  words per line (power of two, >= 2)
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high
//   rreq       line-fill request            (sampled in IDLE only)
//   wreq       single-word write request    (sampled in IDLE only)
//   addr       byte address of the request
//   wdata      write data
//   rdata      critical word of the last fill
//   miss       high while busy, low for exactly one cycle on completion
//   fill_we    one-cycle strobe: write fill_data into line slot fill_idx
//   fill_idx   word slot within the line
//   fill_data  fill word
//   bus_rreq   bus read request
//   bus_wreq   bus write request
//   bus_addr   transaction address (word aligned)
//   bus_wdata  transaction write data
//   bus_acc    bus grant / accept
//   bus_busy   read data not yet valid
//   bus_rdata  bus read data
// -----------------------------------------------------------------------------
module line_loader #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  localparam int OFS       = $clog2(DATA_W / 8),
  localparam int IW        = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rreq,
  input  logic              wreq,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              miss,
  output logic              fill_we,
  output logic [IW-1:0]     fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              bus_rreq,
  output logic              bus_wreq,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_acc,
  input  logic              bus_busy,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RREQ,
    RDELAY,
    RWAIT,
    WREQ,
    WWAIT,
    DONE
  } state_t;

  localparam logic [IW-1:0] LAST_CNT = IW'(LINE_WORDS - 1);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t              state_reg,     state_next;
  logic [ADDR_W-1:0]   addr_reg,      addr_next;
  logic [DATA_W-1:0]   wdata_reg,     wdata_next;
  logic [IW-1:0]       idx_reg,       idx_next;    // slot of the word in flight
  logic [IW-1:0]       cnt_reg,       cnt_next;    // words already captured
  logic [DATA_W-1:0]   rdata_reg,     rdata_next;
  logic                miss_reg,      miss_next;
  logic                fill_we_reg,   fill_we_next;
  logic [IW-1:0]       fill_idx_reg,  fill_idx_next;
  logic [DATA_W-1:0]   fill_data_reg, fill_data_next;
  logic                bus_rreq_reg,  bus_rreq_next;
  logic                bus_wreq_reg,  bus_wreq_next;
  logic [ADDR_W-1:0]   bus_addr_reg,  bus_addr_next;
  logic [DATA_W-1:0]   bus_wdata_reg, bus_wdata_next;

  // ---------------------------------------------------------------------------
  // Address helpers
  // ---------------------------------------------------------------------------
  // Mask clearing the byte-offset bits. Built bit by bit so that OFS = 0
  // (byte-wide words) needs no zero-width replication.
  logic [ADDR_W-1:0] word_mask;

  for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_word_mask
    assign word_mask[gi] = (gi >= OFS);
  end

  // Critical word slot of the latched request.
  logic [IW-1:0] crit_idx;
  assign crit_idx = addr_reg[OFS +: IW];

  // First slot to fetch, taken from the live address while still in IDLE.
  logic [IW-1:0] start_idx;
`ifdef LINE_LOADER_CRITICAL_WORD_FIRST_EN
  assign start_idx = addr[OFS +: IW];
`else
  assign start_idx = '0;
`endif

  // Bus address of the word in flight: line base, current slot, offset zeroed.
  logic [ADDR_W-1:0] rd_addr;
  always_comb begin
    rd_addr            = addr_reg;
    rd_addr[OFS +: IW] = idx_reg;
    rd_addr            = rd_addr & word_mask;
  end

  // Write address: latched address with the byte offset dropped.
  logic [ADDR_W-1:0] wr_addr;
  assign wr_addr = addr_reg & word_mask;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      rdata_reg     <= '0;
      miss_reg      <= 1'b1;
      fill_we_reg   <= 1'b0;
      fill_idx_reg  <= '0;
      fill_data_reg <= '0;
      bus_rreq_reg  <= 1'b0;
      bus_wreq_reg  <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      rdata_reg     <= rdata_next;
      miss_reg      <= miss_next;
      fill_we_reg   <= fill_we_next;
      fill_idx_reg  <= fill_idx_next;
      fill_data_reg <= fill_data_next;
      bus_rreq_reg  <= bus_rreq_next;
      bus_wreq_reg  <= bus_wreq_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Everything holds by default; fill_we is a pulse and miss is only
    // released on the edge entering DONE.
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    idx_next       = idx_reg;
    cnt_next       = cnt_reg;
    rdata_next     = rdata_reg;
    miss_next      = 1'b1;
    fill_we_next   = 1'b0;
    fill_idx_next  = fill_idx_reg;
    fill_data_next = fill_data_reg;
    bus_rreq_next  = bus_rreq_reg;
    bus_wreq_next  = bus_wreq_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;

    unique case (state_reg)
      IDLE: begin
        // A read wins when both requests arrive together.
        if (rreq) begin
          addr_next     = addr;
          idx_next      = start_idx;
          cnt_next      = '0;
          bus_rreq_next = 1'b1;
          state_next    = RREQ;
        end else if (wreq) begin
          addr_next     = addr;
          wdata_next    = wdata;
          bus_wreq_next = 1'b1;
          state_next    = WREQ;
        end
      end

      RREQ: begin
        if (bus_acc) begin
          bus_addr_next = rd_addr;
          bus_rreq_next = 1'b0;
          state_next    = RDELAY;
        end
      end

      // The bus needs one cycle before bus_busy is meaningful.
      RDELAY: begin
        state_next = RWAIT;
      end

      RWAIT: begin
        if (!bus_busy) begin
          fill_we_next   = 1'b1;
          fill_idx_next  = idx_reg;
          fill_data_next = bus_rdata;
          if (idx_reg == crit_idx) begin
            rdata_next = bus_rdata;
          end
          if (cnt_reg == LAST_CNT) begin
            miss_next  = 1'b0;
            state_next = DONE;
          end else begin
            // Slot index wraps naturally at IW bits.
            idx_next      = idx_reg + IW'(1);
            cnt_next      = cnt_reg + IW'(1);
            bus_rreq_next = 1'b1;
            state_next    = RREQ;
          end
        end
      end

      WREQ: begin
        if (bus_acc) begin
          bus_addr_next  = wr_addr;
          bus_wdata_next = wdata_reg;
          bus_wreq_next  = 1'b0;
          state_next     = WWAIT;
        end
      end

      // The write is complete once the bus releases its accept.
      WWAIT: begin
        if (!bus_acc) begin
          miss_next  = 1'b0;
          state_next = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rdata     = rdata_reg;
  assign miss      = miss_reg;
  assign fill_we   = fill_we_reg;
  assign fill_idx  = fill_idx_reg;
  assign fill_data = fill_data_reg;
  assign bus_rreq  = bus_rreq_reg;
  assign bus_wreq  = bus_wreq_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;

endmodule

// File: tb/tb_line_loader.sv
// -----------------------------------------------------------------------------
// tb_line_loader
//
// Directed bench for line_loader (ADDR_W=32, DATA_W=32, LINE_WORDS=4).
// The bus responder returns the transaction address as read data, so every
// fill word identifies the slot it came from. Edge numbers count rising clock
// edges from the edge that samples the request (edge 0).
// -----------------------------------------------------------------------------
module tb_line_loader;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int IW         = 2;

`ifdef LINE_LOADER_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rreq = 1'b0;
  logic              wreq = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              miss;
  logic              fill_we;
  logic [IW-1:0]     fill_idx;
  logic [DATA_W-1:0] fill_data;
  logic              bus_rreq;
  logic              bus_wreq;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_acc = 1'b0;
  logic              bus_busy = 1'b0;
  logic [DATA_W-1:0] bus_rdata;

  always #5 clk = ~clk;

  line_loader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rreq      (rreq),
    .wreq      (wreq),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .miss      (miss),
    .fill_we   (fill_we),
    .fill_idx  (fill_idx),
    .fill_data (fill_data),
    .bus_rreq  (bus_rreq),
    .bus_wreq  (bus_wreq),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_acc   (bus_acc),
    .bus_busy  (bus_busy),
    .bus_rdata (bus_rdata)
  );

  // ---------------------------------------------------------------------------
  // Bus responder
  //   mode 0: bus_acc always high, bus_busy always low
  //   mode 1: bus_acc pulses one cycle after acc_delay cycles of request,
  //           then bus_busy stays high for busy_len cycles
  // ---------------------------------------------------------------------------
  int bus_mode  = 0;
  int acc_delay = 0;
  int busy_len  = 0;
  int req_age   = 0;
  int busy_cnt  = 0;

  assign bus_rdata = bus_addr;

  always @(negedge clk) begin
    if (bus_mode == 0) begin
      bus_acc  = 1'b1;
      bus_busy = 1'b0;
      req_age  = 0;
      busy_cnt = 0;
    end else begin
      if (bus_acc) busy_cnt = busy_len;
      bus_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if ((bus_rreq || bus_wreq) && !bus_acc) begin
        if (req_age >= acc_delay) begin
          bus_acc = 1'b1;
          req_age = 0;
        end else begin
          req_age++;
        end
      end else begin
        bus_acc = 1'b0;
        req_age = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  int          n_fill;
  int          got_idx  [8];
  logic [31:0] got_data [8];
  int          miss_edge [4];
  int          miss_low;
  logic [31:0] got_rdata;
  int          rreq_hi;
  int          wreq_hi;

  function automatic int exp_idx(input int crit, input int k);
    return ((CWF ? crit : 0) + k) % LINE_WORDS;
  endfunction

  // Issue a read (optionally with wreq too), hold the request(s) until edge
  // hold_edge, and record everything the DUT does over edges 0..budget.
  task automatic do_fill(input logic [31:0] a, input logic with_w,
                         input int hold_edge, input int budget);
    n_fill    = 0;
    miss_low  = 0;
    rreq_hi   = 0;
    wreq_hi   = 0;
    got_rdata = '0;
    for (int i = 0; i < 4; i++) miss_edge[i] = -1;
    @(negedge clk);
    addr = a;
    rreq = 1'b1;
    wreq = with_w;
    for (int e = 0; e <= budget; e++) begin
      @(posedge clk);
      #1;
      if (e == hold_edge) begin
        rreq = 1'b0;
        wreq = 1'b0;
      end
      if (fill_we) begin
        if (n_fill < 8) begin
          got_idx[n_fill]  = int'(fill_idx);
          got_data[n_fill] = fill_data;
        end
        n_fill++;
      end
      if (!miss) begin
        if (miss_low < 4) miss_edge[miss_low] = e;
        miss_low++;
        got_rdata = rdata;
      end
      if (bus_rreq) rreq_hi++;
      if (bus_wreq) wreq_hi++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (miss !== 1'b1) begin n_err++; $display("FAIL reset_miss: got %0b expected 1", miss); end
    n_cmp++; if (fill_we !== 1'b0) begin n_err++; $display("FAIL reset_fill_we: got %0b expected 0", fill_we); end
    n_cmp++; if (bus_rreq !== 1'b0 || bus_wreq !== 1'b0) begin n_err++; $display("FAIL reset_bus_req: got %0b%0b expected 00", bus_rreq, bus_wreq); end
    n_cmp++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin n_err++; $display("FAIL reset_bus_addr_wdata: got %h %h expected 0 0", bus_addr, bus_wdata); end
    n_cmp++; if (rdata !== 32'h0 || fill_data !== 32'h0 || fill_idx !== 2'd0) begin n_err++; $display("FAIL reset_data: got %h %h %0d expected 0 0 0", rdata, fill_data, fill_idx); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (miss !== 1'b1 || bus_rreq !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: got miss=%0b bus_rreq=%0b expected 1 0", miss, bus_rreq); end
    $display("reset: miss=%0b fill_we=%0b bus_rreq=%0b", miss, fill_we, bus_rreq);
  endtask

  task automatic test_fill_fast;
    bus_mode = 0;
    do_fill(32'h0000_1008, 1'b0, 0, 16);
    n_cmp++; if (n_fill !== 4) begin n_err++; $display("FAIL fast_fill_count: got %0d expected 4", n_fill); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (got_idx[k] !== exp_idx(2, k)) begin n_err++; $display("FAIL fast_idx%0d: got %0d expected %0d", k, got_idx[k], exp_idx(2, k)); end
      n_cmp++; if (got_data[k] !== 32'h1000 + 32'(4 * exp_idx(2, k))) begin n_err++; $display("FAIL fast_data%0d: got %h expected %h", k, got_data[k], 32'h1000 + 32'(4 * exp_idx(2, k))); end
    end
    n_cmp++; if (miss_edge[0] !== 12) begin n_err++; $display("FAIL fast_miss_edge: got %0d expected 12", miss_edge[0]); end
    n_cmp++; if (miss_low !== 1) begin n_err++; $display("FAIL fast_miss_cycles: got %0d expected 1", miss_low); end
    n_cmp++; if (got_rdata !== 32'h1008) begin n_err++; $display("FAIL fast_rdata: got %h expected 00001008", got_rdata); end
    n_cmp++; if (rreq_hi !== 4) begin n_err++; $display("FAIL fast_rreq_cycles: got %0d expected 4", rreq_hi); end
    n_cmp++; if (rdata !== 32'h1008) begin n_err++; $display("FAIL fast_rdata_hold: got %h expected 00001008", rdata); end
    $display("fill fast addr=00001008 fills=%0d miss_edge=%0d rdata=%h", n_fill, miss_edge[0], got_rdata);
  endtask

  task automatic test_fill_slow;
    @(negedge clk);
    acc_delay = 3;
    busy_len  = 2;
    bus_mode  = 1;
    repeat (3) @(negedge clk);
    do_fill(32'h0000_1004, 1'b0, 0, 32);
    n_cmp++; if (n_fill !== 4) begin n_err++; $display("FAIL slow_fill_count: got %0d expected 4", n_fill); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (got_idx[k] !== exp_idx(1, k) || got_data[k] !== 32'h1000 + 32'(4 * exp_idx(1, k))) begin
        n_err++; $display("FAIL slow_word%0d: got idx=%0d data=%h expected idx=%0d data=%h", k, got_idx[k], got_data[k], exp_idx(1, k), 32'h1000 + 32'(4 * exp_idx(1, k)));
      end
    end
    n_cmp++; if (miss_edge[0] !== 28) begin n_err++; $display("FAIL slow_miss_edge: got %0d expected 28", miss_edge[0]); end
    n_cmp++; if (rreq_hi !== 16) begin n_err++; $display("FAIL slow_rreq_cycles: got %0d expected 16", rreq_hi); end
    n_cmp++; if (got_rdata !== 32'h1004) begin n_err++; $display("FAIL slow_rdata: got %h expected 00001004", got_rdata); end
    $display("fill slow addr=00001004 fills=%0d miss_edge=%0d rdata=%h", n_fill, miss_edge[0], got_rdata);
  endtask

  task automatic test_write;
    int w_miss_edge;
    int w_miss_low;
    int w_fills;
    w_miss_edge = -1;
    w_miss_low  = 0;
    w_fills     = 0;
    @(negedge clk);
    acc_delay = 0;
    bus_mode  = 1;
    repeat (3) @(negedge clk);
    addr  = 32'h0000_2003;
    wdata = 32'hDEAD_BEEF;
    wreq  = 1'b1;
    @(posedge clk);
    #1;
    wreq = 1'b0;
    n_cmp++; if (bus_wreq !== 1'b1 || bus_rreq !== 1'b0) begin n_err++; $display("FAIL write_req: got wreq=%0b rreq=%0b expected 1 0", bus_wreq, bus_rreq); end
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        n_cmp++; if (bus_addr !== 32'h2000) begin n_err++; $display("FAIL write_addr: got %h expected 00002000", bus_addr); end
        n_cmp++; if (bus_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL write_wdata: got %h expected deadbeef", bus_wdata); end
        n_cmp++; if (bus_wreq !== 1'b0) begin n_err++; $display("FAIL write_req_drop: got %0b expected 0", bus_wreq); end
      end
      if (fill_we) w_fills++;
      if (!miss) begin
        if (w_miss_edge < 0) w_miss_edge = e;
        w_miss_low++;
      end
    end
    n_cmp++; if (w_miss_edge !== 2) begin n_err++; $display("FAIL write_miss_edge: got %0d expected 2", w_miss_edge); end
    n_cmp++; if (w_miss_low !== 1 || w_fills !== 0) begin n_err++; $display("FAIL write_side_effects: got miss_low=%0d fills=%0d expected 1 0", w_miss_low, w_fills); end
    $display("write addr=00002003 bus_addr=%h bus_wdata=%h miss_edge=%0d", bus_addr, bus_wdata, w_miss_edge);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus_mode = 0;
    repeat (2) @(negedge clk);
    // rreq and wreq together, held through DONE into the following IDLE.
    do_fill(32'h0000_3004, 1'b1, 14, 30);
    n_cmp++; if (wreq_hi !== 0) begin n_err++; $display("FAIL b2b_no_wreq: got %0d expected 0", wreq_hi); end
    n_cmp++; if (n_fill !== 8) begin n_err++; $display("FAIL b2b_fill_count: got %0d expected 8", n_fill); end
    n_cmp++; if (miss_low !== 2 || miss_edge[0] !== 12 || miss_edge[1] !== 26) begin
      n_err++; $display("FAIL b2b_miss: got count=%0d edges=%0d,%0d expected 2 12,26", miss_low, miss_edge[0], miss_edge[1]);
    end
    n_cmp++; if (got_idx[4] !== exp_idx(1, 0) || got_data[4] !== 32'h3000 + 32'(4 * exp_idx(1, 0))) begin
      n_err++; $display("FAIL b2b_second_start: got idx=%0d data=%h expected idx=%0d data=%h", got_idx[4], got_data[4], exp_idx(1, 0), 32'h3000 + 32'(4 * exp_idx(1, 0)));
    end
    n_cmp++; if (got_rdata !== 32'h3004) begin n_err++; $display("FAIL b2b_rdata: got %h expected 00003004", got_rdata); end
    $display("back_to_back addr=00003004 fills=%0d miss_edges=%0d,%0d bus_wreq_cycles=%0d", n_fill, miss_edge[0], miss_edge[1], wreq_hi);
  endtask

  task automatic test_reset_mid_fill;
    int fills;
    int late_fills;
    fills      = 0;
    late_fills = 0;
    @(negedge clk);
    bus_mode = 0;
    addr     = 32'h0000_1008;
    rreq     = 1'b1;
    @(posedge clk);
    #1;
    rreq = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (fill_we) fills++;
    end
    n_cmp++; if (fills !== 2) begin n_err++; $display("FAIL mid_pre_fills: got %0d expected 2", fills); end
    // Edge 6 has just strobed the second word; reset acts without a clock.
    reset = 1'b1;
    #1;
    n_cmp++; if (fill_we !== 1'b0 || bus_rreq !== 1'b0 || miss !== 1'b1) begin
      n_err++; $display("FAIL mid_async: got fill_we=%0b bus_rreq=%0b miss=%0b expected 0 0 1", fill_we, bus_rreq, miss);
    end
    n_cmp++; if (fill_idx !== 2'd0 || fill_data !== 32'h0 || rdata !== 32'h0 || bus_addr !== 32'h0) begin
      n_err++; $display("FAIL mid_async_data: got idx=%0d data=%h rdata=%h bus_addr=%h expected 0 0 0 0", fill_idx, fill_data, rdata, bus_addr);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      if (fill_we || bus_rreq) late_fills++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (fill_we || bus_rreq || !miss) late_fills++;
    end
    n_cmp++; if (late_fills !== 0) begin n_err++; $display("FAIL mid_no_activity: got %0d expected 0", late_fills); end
    do_fill(32'h0000_1008, 1'b0, 0, 16);
    n_cmp++; if (n_fill !== 4 || got_idx[0] !== exp_idx(2, 0)) begin
      n_err++; $display("FAIL mid_restart: got fills=%0d first_idx=%0d expected 4 %0d", n_fill, got_idx[0], exp_idx(2, 0));
    end
    n_cmp++; if (miss_edge[0] !== 12 || got_rdata !== 32'h1008) begin
      n_err++; $display("FAIL mid_restart_done: got edge=%0d rdata=%h expected 12 00001008", miss_edge[0], got_rdata);
    end
    $display("reset_mid_fill pre_fills=%0d restart_fills=%0d miss_edge=%0d", fills, n_fill, miss_edge[0]);
  endtask

  initial begin
    test_reset();
    test_fill_fast();
    test_fill_slow();
    test_write();
    test_back_to_back();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case a stimulus loop never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/line_loader.md
# line_loader

Parametrised L1 refill/write-through engine between the L1 cache controller and the shared memory bus. A read request fetches a whole line of `LINE_WORDS` words as back-to-back single-word bus transactions, streams each word into the cache data RAM, and returns the requested word. A write request performs one single-word bus write. Each bus transaction uses the bus's request/accept/busy handshake.

## Interface
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, word width; power of two, ≥8.
- `LINE_WORDS`, 4, words per line; power of two, ≥2.
- Derived: `OFS = log2(DATA_W/8)`, `IW = log2(LINE_WORDS)`.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; all state and outputs to reset values immediately.
- `rreq`  in  1  line-fill request.
- `wreq`  in  1  single-word write request.
- `addr`  in  ADDR_W  byte address of the request.
- `wdata`  in  DATA_W  write data.
- `rdata`  out  DATA_W  requested word of the last fill.
- `miss`  out  1  high while not done; low exactly one cycle on completion.
- `fill_we`  out  1  one-cycle strobe: write `fill_data` into line slot `fill_idx`.
- `fill_idx`  out  IW  word slot within the line.
- `fill_data`  out  DATA_W  fill word.
- `bus_rreq`, `bus_wreq`  out  1  bus read/write request.
- `bus_addr`  out  ADDR_W  transaction address.
- `bus_wdata`  out  DATA_W  write data.
- `bus_acc`  in  1  bus grant/accept.
- `bus_busy`  in  1  read data not yet valid.
- `bus_rdata`  in  DATA_W  read data.

## Operation
- Reset values: `miss`=1; every other output =0.
- States: IDLE, RREQ, RDELAY, RWAIT, WREQ, WWAIT, DONE.
- IDLE:
  - `rreq` → latch `addr`, set `idx` to the start index, raise `bus_rreq`, go to RREQ.
  - Else `wreq` → latch `addr` and `wdata`, raise `bus_wreq`, go to WREQ.
  - `rreq` and `wreq` together: the read wins.
- RREQ: hold `bus_rreq` until `bus_acc`. On `bus_acc`, drive `bus_addr = {line_base, idx, OFS zeros}`, drop `bus_rreq`, go to RDELAY.
- RDELAY: one cycle unconditionally, then RWAIT.
- RWAIT: wait for `!bus_busy`, then:
  - Register `fill_we`=1, `fill_idx`=idx, `fill_data`=`bus_rdata`.
  - If idx is the critical index (`addr[OFS+IW-1:OFS]`), also load `rdata`.
  - If this was the LINE_WORDS-th word, go to DONE. Otherwise advance idx (wrapping modulo LINE_WORDS), raise `bus_rreq`, go to RREQ.
- WREQ: on `bus_acc`, drive `bus_addr` (latched address, low OFS bits zeroed) and `bus_wdata`, drop `bus_wreq`, go to WWAIT.
- WWAIT: wait for `!bus_acc`, then go to DONE.
- DONE: `miss`=0 for this one cycle only, then IDLE.
- `fill_we` is a one-cycle pulse. `fill_idx` and `fill_data` hold their values until the next strobe.
- `addr`, `wdata`, `rreq`, `wreq` are ignored outside IDLE. Dropping a request mid-transaction does not abort it.
- A request still asserted in the IDLE cycle after DONE starts a new transaction. The requester must drop it during the DONE cycle.
- Reset mid-transaction: requests drop at once and the FSM returns to IDLE. Any partial line is abandoned with no further `fill_we`.

## Timing
- Each read word takes at least 3 edges: RREQ accept, RDELAY, RWAIT capture.
- Line fill, with `bus_acc` present in the first RREQ cycle and `bus_busy` low: `miss` falls 3·LINE_WORDS edges after the edge that sampled `rreq`. For LINE_WORDS=4 that is edge 12.
- Write, with `bus_acc` high for exactly one cycle: `miss` falls 2 edges after the sampling edge.
- `bus_rreq` drops on the accept edge and re-rises on the capture edge for the next word.
- `rdata` is valid whenever `miss`=0 after a fill, and stays stable until the next fill captures the critical word.

## Configuration
- `LINE_LOADER_CRITICAL_WORD_FIRST_EN`
  - Defined: start index = critical index; fill order wraps, e.g. with LINE_WORDS=4 and critical index 2 the order is 2,3,0,1.
  - Undefined: start index = 0 and the order is strictly 0..LINE_WORDS-1, whatever `addr` is.
  - Either way, total latency and `rdata` content are identical.

## Test plan
- Reset mid-fill after 2 words: outputs return to reset values immediately, no further `fill_we`, and the next `rreq` restarts cleanly at the start index.
- `rreq`, addr=0x1008, LINE_WORDS=4, `bus_acc` always high, `bus_busy` low, bus returns word = address:
  - Macro undefined: fills 0x1000/0x1004/0x1008/0x100C at idx 0..3; `rdata`=0x1008; `miss` low on edge 12 for one cycle.
- Same stimulus, macro defined: order idx 2,3,0,1 (addresses 0x1008, 0x100C, 0x1000, 0x1004); `rdata`=0x1008; same latency.
- `bus_acc` delayed 3 cycles per word and `bus_busy` high for 2 cycles: `bus_rreq` is held until `bus_acc`; each word is captured only when `bus_busy` is low; 4 `fill_we` pulses total.
- `wreq`, addr=0x2003, wdata=0xDEADBEEF: `bus_addr`=0x2000, `bus_wdata`=0xDEADBEEF; `miss` low one cycle after `bus_acc` falls.
- `rreq` and `wreq` together: read executes, no `bus_wreq`. Holding `rreq` high through DONE starts a second fill.
